// File: rtl/dsp_ram_arbiter.sv
// Audio RAM read-port arbiter: round-robin over NUM_REQ requesters, optional
// strict priority for requester 0, tagged pipeline routes read data back.
module dsp_ram_arbiter #(
  parameter int NUM_REQ     = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int RAM_LATENCY = 1,
  parameter int PRIO0       = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_read,
  input  logic [DATA_W-1:0]         ram_data,
  output logic [3:0]                last_grant
);

  localparam logic [NUM_REQ-1:0] ONE =
    {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [3:0] LAST_RST = 4'(NUM_REQ - 1);

  logic [15:0]       vld_pad;
  logic [ADDR_W-1:0] addr_arr [16];
  logic              gnt_vld;
  logic              gnt_rr;
  logic [3:0]        gnt_id;
  logic [3:0]        idx;

  logic [3:0]         last_grant_q, last_grant_d;
  logic               ram_read_q;
  logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
  logic [RAM_LATENCY:0] tag_v_q;
  logic [3:0]         tag_id_q [RAM_LATENCY+1];
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  always_comb begin
    vld_pad = 16'(req_valid);
    for (int i = 0; i < 16; i++) addr_arr[i] = '0;
    for (int i = 0; i < NUM_REQ; i++)
      addr_arr[i] = req_address[i*ADDR_W +: ADDR_W];
  end

  // Walk the search order backwards so the first hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_rr  = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (reset) begin
      if (PRIO0 != 0 && vld_pad[0]) begin
        gnt_vld = 1'b1;
      end else begin
        for (int j = NUM_REQ; j >= 1; j--) begin
          idx = 4'((int'(last_grant_q) + j) % NUM_REQ);
          if (vld_pad[idx] && !(PRIO0 != 0 && idx == 4'd0)) begin
            gnt_vld = 1'b1;
            gnt_rr  = 1'b1;
            gnt_id  = idx;
          end
        end
      end
    end
  end

  assign req_ready = gnt_vld ? (ONE << gnt_id) : '0;

  always_comb begin
    last_grant_d  = gnt_rr ? gnt_id : last_grant_q;
    ram_address_d = gnt_vld ? addr_arr[gnt_id] : ram_address_q;
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    if (tag_v_q[RAM_LATENCY]) begin
      rsp_valid_d = ONE << tag_id_q[RAM_LATENCY];
      rsp_data_d  = ram_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= LAST_RST;
      ram_read_q    <= 1'b0;
      ram_address_q <= '0;
      tag_v_q       <= '0;
      for (int i = 0; i <= RAM_LATENCY; i++) tag_id_q[i] <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      ram_read_q    <= gnt_vld;
      ram_address_q <= ram_address_d;
      tag_v_q       <= {tag_v_q[RAM_LATENCY-1:0], gnt_vld};
      tag_id_q[0]   <= gnt_id;
      for (int i = 1; i <= RAM_LATENCY; i++)
        tag_id_q[i] <= tag_id_q[i-1];
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign last_grant  = last_grant_q;
  assign ram_read    = ram_read_q;
  assign ram_address = ram_address_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: doc/dsp_ram_arbiter.md
Name: dsp_ram_arbiter

Overview:
- Shares the single 64 KiB audio RAM read port between up to NUM_REQ requesters: the DSP voice decoders, plus requester 0 for the CPU/echo path.
- Uses round-robin arbitration with optional strict priority for requester 0.
- Pipelined: one RAM read issued per cycle, each response routed back to its originator via a tag pipeline.
- Sits between the voice decoders' RAM request ports and the audio RAM.

Parameters:
- NUM_REQ, 8, number of requesters (2..16).
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RAM_LATENCY, 1, cycles from ram_read asserted to ram_data valid (1..4).
- PRIO0, 1, 1 = requester 0 has strict priority over round-robin; 0 = requester 0 joins round-robin.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  NUM_REQ  per-requester read request.
- req_address  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_ready  output  NUM_REQ  one-hot accept, combinational, same cycle.
- rsp_valid  output  NUM_REQ  one-hot, registered; rsp_data belongs to this requester.
- rsp_data  output  DATA_W  registered read data, shared by all requesters.
- ram_address  output  ADDR_W  registered RAM address.
- ram_read  output  1  registered RAM read strobe.
- ram_data  input  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_read.
- last_grant  output  4  round-robin pointer, debug.

Behaviour:
- Reset (reset=0, asynchronous):
  - ram_read=0, ram_address=0, rsp_valid=0, rsp_data=0.
  - last_grant=NUM_REQ-1.
  - Tag pipeline cleared.
  - In-flight reads are discarded: no rsp_valid for them after reset release.
- Handshake:
  - A requester holds req_valid and its address stable until it sees req_ready.
  - A transfer occurs in cycle T when req_valid[i] & req_ready[i].
  - Dropping req_valid before acceptance is permitted; no read is issued.
- Grant selection (combinational, each cycle):
  - If PRIO0=1 and req_valid[0], grant 0.
  - Else grant the first requester with req_valid set, searching from last_grant+1 upward modulo NUM_REQ.
  - If PRIO0=1, index 0 is skipped in the round-robin search.
  - At most one req_ready bit is high; req_ready=0 when no request is pending.
- Pointer:
  - last_grant <= granted index only on round-robin grants.
  - Priority grants of requester 0 leave last_grant unchanged.
  - No grant: pointer holds.
- Issue: cycle T+1: ram_read=1 and ram_address=req_address[g]. With no grant, ram_read=0 and ram_address holds its last value.
- Tag pipeline:
  - Depth RAM_LATENCY+1 entries of {valid, id}.
  - Entered at T+1 alongside ram_read; shifts every cycle.
  - No stalls: accepts back-to-back grants every cycle.
- Response:
  - ram_data is sampled at T+1+RAM_LATENCY.
  - Cycle T+2+RAM_LATENCY: rsp_data=sampled data, rsp_valid[id]=1 for exactly one cycle.
  - Total accept-to-response latency = RAM_LATENCY+2 cycles (3 at default).
- Ordering: responses return in grant order. A requester issuing back-to-back reads receives responses in request order on consecutive cycles.
- rsp_data holds its last value when rsp_valid=0.
- Fairness:
  - With all requesters continuously valid and PRIO0=0, each is granted once per NUM_REQ cycles.
  - With PRIO0=1, continuous requester 0 starves the others by design.
- Boundaries:
  - Address wrap 16'hFFFF is passed through unchanged.
  - A request asserted in the same cycle reset deasserts is not granted until the first clock edge after release.
  - A requester valid on grant and re-asserting next cycle is eligible again. Round-robin puts it last among the other pending requesters.

Test Plan:
- Reset: hold reset=0 with req_valid=8'hFF -> req_ready=0, ram_read=0, rsp_valid=0, last_grant=7. Release -> first grant is requester 0 (PRIO0=0), ram_read=1 one cycle later.
- Single read: requester 3 requests addr 16'h1234, RAM model returns 8'hA5 -> req_ready[3] at T, ram_address=16'h1234 at T+1, rsp_valid=8'b0000_1000 and rsp_data=8'hA5 at T+3.
- Round-robin: PRIO0=0, all 8 valid for 16 cycles, addresses 16'h0100+i -> grant order 0..7,0..7. Each requester gets exactly 2 responses, each carrying data = RAM[16'h0100+i].
- Priority: PRIO0=1, requesters 0, 2 and 5 continuously valid -> requester 0 granted every cycle while valid. Drop requester 0 -> grants alternate 2,5,2,5, with last_grant updating 2->5->2.
- Latency sweep: RAM_LATENCY=3, back-to-back reads by requester 1 at 16'h0010..16'h0013 -> four responses on consecutive cycles, the first 5 cycles after the first accept, in address order.
- Reset mid-flight: assert reset one cycle after ram_read is issued for requester 6 -> no rsp_valid[6] after release. Pipeline is empty and the next request completes normally.
